board_sequencer: RTL and testbench

- Game-progress stage directly upstream of the board renderer. Decides which board (screen) is shown and which player has right of way.
- Detects when the right-of-way player exits the screen edge and steps the board index. Holds a transition period, then declares the win.
- Drives the renderer's board_in / board_change inputs and the player-respawn and freeze controls.

---
 rtl/board_sequencer_pkg.sv | 45 ++++
 rtl/board_sequencer_if.sv | 33 +++
 rtl/board_sequencer_frame_tick.sv | 21 ++
 rtl/board_sequencer.sv | 132 +++++++++++++
 tb/tb_board_sequencer.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/board_sequencer_pkg.sv
// Shared game-progress definitions: sequencer states, right-of-way encoding,
// board_change codes (also decoded by the renderer) and board index helpers.
package board_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_PLAY       = 2'd0,
        ST_TRANSITION = 2'd1,
        ST_WIN        = 2'd2
    } seq_state_e;

    typedef enum logic [1:0] {
        PRIO_NONE  = 2'b00,
        PRIO_LEFT  = 2'b01,
        PRIO_RIGHT = 2'b10
    } prio_e;

    typedef enum logic [1:0] {
        BC_IDLE      = 2'b00,
        BC_RIGHT_ADV = 2'b01,
        BC_LEFT_ADV  = 2'b10
    } board_change_e;

    localparam logic signed [2:0] LAST_BOARD = 3'sd2;

    localparam logic [11:0] EDGE_LO_DEFAULT      = 12'd16;
    localparam logic [11:0] EDGE_HI_DEFAULT      = 12'd1008;
    localparam logic [7:0]  TRANS_FRAMES_DEFAULT = 8'd30;

    // Right player advancing moves the index towards +LAST_BOARD, left towards -LAST_BOARD.
    function automatic logic signed [2:0] step_index(input logic signed [2:0] idx,
                                                     input logic               toward_pos);
        logic signed [2:0] nxt;
        if (toward_pos) begin
            nxt = (idx >= LAST_BOARD) ? LAST_BOARD : idx + 3'sd1;
        end else begin
            nxt = (idx <= -LAST_BOARD) ? -LAST_BOARD : idx - 3'sd1;
        end
        return nxt;
    endfunction

    function automatic logic at_last_board(input logic signed [2:0] idx);
        return (idx == LAST_BOARD) || (idx == -LAST_BOARD);
    endfunction

endpackage

// File: rtl/board_sequencer_if.sv
// Game-progress bundle between player logic / VGA timing and the board sequencer.
// kill_L/kill_R are single-cycle strobes, restart is a level; every sequencer output is registered.
interface board_sequencer_if;

    logic        vsync_in;
    logic [11:0] xpos_playerL;
    logic [11:0] xpos_playerR;
    logic        kill_L;
    logic        kill_R;
    logic        restart;

    logic [2:0]  board_in_out;
    logic [1:0]  board_change;
    logic [1:0]  player_priority;
    logic        respawn;
    logic        freeze;
    logic        winL;
    logic        winR;
    logic [1:0]  dbg_state;

    modport master (
        output vsync_in, xpos_playerL, xpos_playerR, kill_L, kill_R, restart,
        input  board_in_out, board_change, player_priority, respawn, freeze,
               winL, winR, dbg_state
    );

    modport slave (
        input  vsync_in, xpos_playerL, xpos_playerR, kill_L, kill_R, restart,
        output board_in_out, board_change, player_priority, respawn, freeze,
               winL, winR, dbg_state
    );

endinterface

// File: rtl/board_sequencer_frame_tick.sv
// vsync rising-edge detector: one-cycle frame tick, reusable by sprite animation blocks.
module board_sequencer_frame_tick (
    input  logic clk,
    input  logic rst,
    input  logic i_vsync,
    output logic o_tick
);

    logic r_vsync_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vsync_d <= 1'b0;
        end else begin
            r_vsync_d <= i_vsync;
        end
    end

    assign o_tick = i_vsync & ~r_vsync_d;

endmodule

// File: rtl/board_sequencer.sv
// Board sequencer: tracks right of way, steps the board index when the holder exits
// the far edge, holds a frozen transition period and declares the win at the last board.
module board_sequencer
    import board_sequencer_pkg::*;
#(
    parameter logic [11:0] EDGE_LO      = EDGE_LO_DEFAULT,
    parameter logic [11:0] EDGE_HI      = EDGE_HI_DEFAULT,
    parameter logic [7:0]  TRANS_FRAMES = TRANS_FRAMES_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    board_sequencer_if.slave  io_seq
);

    logic w_tick;

    board_sequencer_frame_tick u_frame_tick (
        .clk     (clk),
        .rst     (reset),
        .i_vsync (io_seq.vsync_in),
        .o_tick  (w_tick)
    );

    seq_state_e        r_state;
    prio_e             r_prio;
    board_change_e     r_change;
    logic signed [2:0] r_index;
    logic [7:0]        r_count;
    logic              r_respawn;
    logic              r_freeze;
    logic              r_winL;
    logic              r_winR;

    logic w_kill_only_L;
    logic w_kill_only_R;
    logic w_exit_right;
    logic w_exit_left;
    logic w_last_frame;

    // Simultaneous kills cancel out and leave right of way where it was.
    assign w_kill_only_L = io_seq.kill_L & ~io_seq.kill_R;
    assign w_kill_only_R = io_seq.kill_R & ~io_seq.kill_L;

    // Only the right-of-way holder's position matters, so at most one exit fires.
    assign w_exit_right = (r_prio == PRIO_RIGHT) && (io_seq.xpos_playerR <= EDGE_LO);
    assign w_exit_left  = (r_prio == PRIO_LEFT)  && (io_seq.xpos_playerL >= EDGE_HI);
    assign w_last_frame = (r_count == TRANS_FRAMES - 8'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_PLAY;
            r_prio    <= PRIO_NONE;
            r_change  <= BC_IDLE;
            r_index   <= 3'sd0;
            r_count   <= 8'd0;
            r_respawn <= 1'b0;
            r_freeze  <= 1'b0;
            r_winL    <= 1'b0;
            r_winR    <= 1'b0;
        end else begin
            r_respawn <= 1'b0;
            case (r_state)
                ST_PLAY: begin
                    if (w_kill_only_L) begin
                        r_prio <= PRIO_LEFT;
                    end else if (w_kill_only_R) begin
                        r_prio <= PRIO_RIGHT;
                    end
                    if (w_tick && w_exit_right) begin
                        r_index  <= step_index(r_index, 1'b1);
                        r_change <= BC_RIGHT_ADV;
                        r_count  <= 8'd0;
                        r_freeze <= 1'b1;
                        r_state  <= ST_TRANSITION;
                    end else if (w_tick && w_exit_left) begin
                        r_index  <= step_index(r_index, 1'b0);
                        r_change <= BC_LEFT_ADV;
                        r_count  <= 8'd0;
                        r_freeze <= 1'b1;
                        r_state  <= ST_TRANSITION;
                    end
                end

                ST_TRANSITION: begin
                    if (w_tick) begin
                        if (w_last_frame) begin
                            r_change <= BC_IDLE;
                            if (at_last_board(r_index)) begin
                                r_state <= ST_WIN;
                                r_winR  <= (r_index == LAST_BOARD);
                                r_winL  <= (r_index == -LAST_BOARD);
                            end else begin
                                r_state   <= ST_PLAY;
                                r_freeze  <= 1'b0;
                                r_respawn <= 1'b1;
                            end
                        end else begin
                            r_count <= r_count + 8'd1;
                        end
                    end
                end

                ST_WIN: begin
                    if (io_seq.restart) begin
                        r_state   <= ST_PLAY;
                        r_index   <= 3'sd0;
                        r_prio    <= PRIO_NONE;
                        r_change  <= BC_IDLE;
                        r_winL    <= 1'b0;
                        r_winR    <= 1'b0;
                        r_freeze  <= 1'b0;
                        r_respawn <= 1'b1;
                    end
                end

                default: begin
                    r_state <= ST_PLAY;
                end
            endcase
        end
    end

    assign io_seq.board_in_out    = r_index;
    assign io_seq.board_change    = r_change;
    assign io_seq.player_priority = r_prio;
    assign io_seq.respawn         = r_respawn;
    assign io_seq.freeze          = r_freeze;
    assign io_seq.winL            = r_winL;
    assign io_seq.winR            = r_winR;
    assign io_seq.dbg_state       = r_state;

endmodule

// File: tb/tb_board_sequencer.sv
// Self-checking bench for board_sequencer: expected output vectors are queued with
// each stimulus step and compared against the DUT after the following clock edge.
module tb_board_sequencer;
    import board_sequencer_pkg::*;

    logic clk;
    logic rst;

    board_sequencer_if u_if ();

    board_sequencer u_dut (
        .clk    (clk),
        .reset  (rst),
        .io_seq (u_if)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [10:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    function automatic logic [10:0] pk(input int idx, input logic [1:0] chg, input logic [1:0] pr,
                                       input logic rsp, input logic frz, input logic wl, input logic wr);
        logic [2:0] i3;
        i3 = idx[2:0];
        return {i3, chg, pr, rsp, frz, wl, wr};
    endfunction

    function automatic logic [10:0] obs();
        return {u_if.board_in_out, u_if.board_change, u_if.player_priority,
                u_if.respawn, u_if.freeze, u_if.winL, u_if.winR};
    endfunction

    task automatic check(input string tag, input logic [10:0] got, input logic [10:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %b expected %b  (idx,chg,prio,rsp,frz,wL,wR)", tag, got, exp);
        end
    endtask

    task automatic expect_out(input logic [10:0] e);
        exp_q.push_back(e);
    endtask

    task automatic sample(input string tag);
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL %s: scoreboard empty, got %b expected <queued value>", tag, obs());
        end else begin
            check(tag, obs(), exp_q.pop_front());
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        u_if.vsync_in = 1'b0;
        clk_step();
        u_if.vsync_in = 1'b1;
        clk_step();
        u_if.vsync_in = 1'b0;
    endtask

    task automatic pulse_kill(input logic kl, input logic kr);
        u_if.kill_L = kl;
        u_if.kill_R = kr;
        clk_step();
        u_if.kill_L = 1'b0;
        u_if.kill_R = 1'b0;
    endtask

    task automatic run_transition(input int n_hold, input logic [10:0] hold_e,
                                  input logic [10:0] exit_e, input string exit_tag);
        for (int i = 0; i < n_hold; i++) begin
            expect_out(hold_e);
            tick();
            sample("trans_hold");
        end
        expect_out(exit_e);
        tick();
        sample(exit_tag);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst               = 1'b1;
        u_if.vsync_in     = 1'b0;
        u_if.xpos_playerL = 12'd500;
        u_if.xpos_playerR = 12'd500;
        u_if.kill_L       = 1'b0;
        u_if.kill_R       = 1'b0;
        u_if.restart      = 1'b0;

        repeat (3) clk_step();
        expect_out(pk(0, 2'b00, 2'b00, 0, 0, 0, 0));
        sample("reset");
        check("reset_state", 11'(u_if.dbg_state), 11'(ST_PLAY));
        rst = 1'b0;

        // Edge positions reached but nobody holds right of way.
        u_if.xpos_playerR = 12'd10;
        u_if.xpos_playerL = 12'd1010;
        for (int i = 0; i < 4; i++) begin
            expect_out(pk(0, 2'b00, 2'b00, 0, 0, 0, 0));
            tick();
            sample("idle_no_prio");
        end

        expect_out(pk(0, 2'b00, 2'b10, 0, 0, 0, 0));
        pulse_kill(1'b0, 1'b1);
        sample("kill_r");

        expect_out(pk(1, 2'b01, 2'b10, 0, 1, 0, 0));
        tick();
        sample("adv_r1");
        check("state_trans", 11'(u_if.dbg_state), 11'(ST_TRANSITION));

        expect_out(pk(1, 2'b01, 2'b10, 0, 1, 0, 0));
        pulse_kill(1'b1, 1'b0);
        sample("kill_in_trans");

        run_transition(29, pk(1, 2'b01, 2'b10, 0, 1, 0, 0),
                       pk(1, 2'b00, 2'b10, 1, 0, 0, 0), "exit_r1");
        expect_out(pk(1, 2'b00, 2'b10, 0, 0, 0, 0));
        clk_step();
        sample("respawn_clear1");

        // Right priority: left player at the right edge does not advance.
        u_if.xpos_playerR = 12'd500;
        u_if.xpos_playerL = 12'd1010;
        expect_out(pk(1, 2'b00, 2'b10, 0, 0, 0, 0));
        tick();
        sample("no_adv_l");

        expect_out(pk(1, 2'b00, 2'b01, 0, 0, 0, 0));
        pulse_kill(1'b1, 1'b0);
        sample("kill_l");

        expect_out(pk(0, 2'b10, 2'b01, 0, 1, 0, 0));
        tick();
        sample("adv_l");

        run_transition(29, pk(0, 2'b10, 2'b01, 0, 1, 0, 0),
                       pk(0, 2'b00, 2'b01, 1, 0, 0, 0), "exit_l");
        expect_out(pk(0, 2'b00, 2'b01, 0, 0, 0, 0));
        clk_step();
        sample("respawn_clear2");

        u_if.xpos_playerL = 12'd500;
        expect_out(pk(0, 2'b00, 2'b10, 0, 0, 0, 0));
        pulse_kill(1'b0, 1'b1);
        sample("kill_r2");
        expect_out(pk(0, 2'b00, 2'b10, 0, 0, 0, 0));
        pulse_kill(1'b1, 1'b1);
        sample("kill_both");

        // Two right advances reach +LAST_BOARD.
        u_if.xpos_playerR = 12'd10;
        expect_out(pk(1, 2'b01, 2'b10, 0, 1, 0, 0));
        tick();
        sample("adv_r2");
        run_transition(29, pk(1, 2'b01, 2'b10, 0, 1, 0, 0),
                       pk(1, 2'b00, 2'b10, 1, 0, 0, 0), "exit_r2");
        expect_out(pk(1, 2'b00, 2'b10, 0, 0, 0, 0));
        clk_step();
        sample("respawn_clear3");

        expect_out(pk(2, 2'b01, 2'b10, 0, 1, 0, 0));
        tick();
        sample("adv_r3");
        run_transition(29, pk(2, 2'b01, 2'b10, 0, 1, 0, 0),
                       pk(2, 2'b00, 2'b10, 0, 1, 0, 1), "win_r");
        check("state_win", 11'(u_if.dbg_state), 11'(ST_WIN));

        expect_out(pk(2, 2'b00, 2'b10, 0, 1, 0, 1));
        pulse_kill(1'b1, 1'b0);
        sample("kill_in_win");
        expect_out(pk(2, 2'b00, 2'b10, 0, 1, 0, 1));
        tick();
        sample("win_hold");

        u_if.restart = 1'b1;
        expect_out(pk(0, 2'b00, 2'b00, 1, 0, 0, 0));
        clk_step();
        u_if.restart = 1'b0;
        sample("restart");
        expect_out(pk(0, 2'b00, 2'b00, 0, 0, 0, 0));
        clk_step();
        sample("restart_clear");
        check("state_play", 11'(u_if.dbg_state), 11'(ST_PLAY));

        // restart is ignored outside WIN.
        u_if.xpos_playerR = 12'd500;
        expect_out(pk(0, 2'b00, 2'b10, 0, 0, 0, 0));
        pulse_kill(1'b0, 1'b1);
        sample("kill_r3");
        u_if.restart = 1'b1;
        expect_out(pk(0, 2'b00, 2'b10, 0, 0, 0, 0));
        clk_step();
        u_if.restart = 1'b0;
        sample("restart_in_play");

        // Reset asserted mid-transition at counter 15.
        u_if.xpos_playerR = 12'd10;
        expect_out(pk(1, 2'b01, 2'b10, 0, 1, 0, 0));
        tick();
        sample("adv_r4");
        for (int i = 0; i < 15; i++) begin
            expect_out(pk(1, 2'b01, 2'b10, 0, 1, 0, 0));
            tick();
            sample("trans_hold_pre_reset");
        end
        #2;
        rst = 1'b1;
        #1;
        expect_out(pk(0, 2'b00, 2'b00, 0, 0, 0, 0));
        sample("async_reset");
        check("async_reset_state", 11'(u_if.dbg_state), 11'(ST_PLAY));
        clk_step();
        clk_step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expect_out(pk(0, 2'b00, 2'b00, 0, 0, 0, 0));
            tick();
            sample("post_reset_idle");
        end

        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
